// File: rtl/pu_riscv_host_csr.sv
// ============================================================================
// pu_riscv_host_csr : core-side tohost/fromhost CSR owner with host req/ack link
// Revision: 1.0
// ============================================================================
`default_nettype none

module pu_riscv_host_csr #(
  parameter int          XLEN          = 32,
  parameter logic [11:0] TOHOST_ADDR   = 12'h780,
  parameter logic [11:0] FROMHOST_ADDR = 12'h781
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  input  logic            host_csr_req,
  output logic            host_csr_ack,
  input  logic            host_csr_we,
  input  logic [XLEN-1:0] host_csr_fromhost,
  output logic [XLEN-1:0] host_csr_tohost,
  output logic            tohost_pending,
  output logic            host_irq
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t            state_q;
  logic              ack_q;
  logic              pending_q;
  logic [XLEN-1:0]   tohost_q;
  logic [XLEN-1:0]   fromhost_q;

  logic              w_cpu_to_wr;
  logic              w_cpu_from_wr;
  logic              w_accept;

  assign w_cpu_to_wr   = csr_we && (csr_addr == TOHOST_ADDR);
  assign w_cpu_from_wr = csr_we && (csr_addr == FROMHOST_ADDR);
  assign w_accept      = (state_q == S_IDLE) && host_csr_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      pending_q  <= 1'b0;
      tohost_q   <= '0;
      fromhost_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (host_csr_req) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end
        end
        S_ACK: begin
          if (!host_csr_req) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
      endcase

      // CPU tohost write outranks a host consume on the same edge
      if (w_cpu_to_wr) begin
        tohost_q  <= csr_wdata;
        pending_q <= |csr_wdata;
      end else if (w_accept && !host_csr_we) begin
        tohost_q  <= '0;
        pending_q <= 1'b0;
      end

      // Host fromhost write outranks a CPU fromhost write on the same edge
      if (w_accept && host_csr_we) begin
        fromhost_q <= host_csr_fromhost;
      end else if (w_cpu_from_wr) begin
        fromhost_q <= csr_wdata;
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    if (csr_addr == TOHOST_ADDR) begin
      csr_rdata = tohost_q;
      csr_hit   = 1'b1;
    end else if (csr_addr == FROMHOST_ADDR) begin
      csr_rdata = fromhost_q;
      csr_hit   = 1'b1;
    end
  end

  assign host_csr_ack    = ack_q;
  assign host_csr_tohost = tohost_q;
  assign tohost_pending  = pending_q;
  assign host_irq        = |fromhost_q;

endmodule

`default_nettype wire
